// File: rtl/p23_store_aligner.sv
// Store aligner: turns a decoded SB/SH/SW request into one or two lane-aligned 32-bit
// write beats with byte strobes, splitting word-crossing stores across two words.
module p23_store_aligner #(
  parameter int MISALIGNED_SPLIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  STOREop,
  input  logic        amo_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  localparam logic [1:0] OP_SB = 2'd0;
  localparam logic [1:0] OP_SH = 2'd1;
  localparam logic [1:0] OP_SW = 2'd2;
  localparam logic       SPLIT_EN = (MISALIGNED_SPLIT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t      state_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
  logic        mem_valid_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;
  logic [31:0] hi_wdata_reg;
  logic [3:0]  hi_wstrb_reg;

  logic [1:0]  op;
  logic [1:0]  off;
  logic [3:0]  base;
  logic [31:0] wdata_masked;
  logic [7:0]  strb_wide;
  logic [63:0] data_wide;
  logic        crossing;
  logic        illegal;
  logic        reject;
  logic        can_accept;

  // AMO write-back always stores a full word.
  assign op  = amo_store ? OP_SW : STOREop;
  assign off = addr[1:0];

  always_comb begin
    base = 4'b0000;
    case (op)
      OP_SB:   base = 4'b0001;
      OP_SH:   base = 4'b0011;
      OP_SW:   base = 4'b1111;
      default: base = 4'b0000;
    endcase
  end

  // The unshifted strobe pattern doubles as the byte-keep mask for the data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign wdata_masked[8*gi +: 8] = base[gi] ? wdata[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign strb_wide  = {4'b0000, base} << off;
  assign data_wide  = {32'h0, wdata_masked} << {off, 3'b000};
  assign crossing   = |strb_wide[7:4];
  assign illegal    = (op == 2'd3);
  assign reject     = illegal | (crossing & ~SPLIT_EN);
  assign can_accept = (state_reg == S_IDLE) || (state_reg == S_FIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      mem_wstrb_reg <= 4'h0;
      hi_wdata_reg  <= 32'h0;
      hi_wstrb_reg  <= 4'h0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (can_accept) begin
        busy_reg      <= 1'b0;
        mem_valid_reg <= 1'b0;
        state_reg     <= S_IDLE;
        if (start) begin
          if (reject) begin
            // Rejected requests never touch the bus; complete immediately.
            state_reg <= S_FIN;
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            state_reg     <= S_BEAT1;
            busy_reg      <= 1'b1;
            mem_valid_reg <= 1'b1;
            mem_addr_reg  <= {addr[31:2], 2'b00};
            mem_wdata_reg <= data_wide[31:0];
            mem_wstrb_reg <= strb_wide[3:0];
            hi_wdata_reg  <= data_wide[63:32];
            hi_wstrb_reg  <= strb_wide[7:4];
          end
        end
      end else if (mem_valid_reg && mem_ready) begin
        if ((state_reg == S_BEAT1) && (hi_wstrb_reg != 4'h0)) begin
          // Second beat follows without a bubble; address wraps modulo 2^32.
          state_reg     <= S_BEAT2;
          mem_addr_reg  <= mem_addr_reg + 32'd4;
          mem_wdata_reg <= hi_wdata_reg;
          mem_wstrb_reg <= hi_wstrb_reg;
        end else begin
          state_reg     <= S_FIN;
          busy_reg      <= 1'b0;
          mem_valid_reg <= 1'b0;
          done_reg      <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;

endmodule

// File: tb/tb_p23_store_aligner.sv
// Directed bench for p23_store_aligner: hand-computed beats for aligned, crossing,
// wrapping, backpressured/AMO, rejected and reset-aborted stores.
module tb_p23_store_aligner;

  logic        clk = 1'b0;
  logic        reset, start, start2, amo_store, mem_ready;
  logic [1:0]  store_op;
  logic [31:0] addr, wdata;

  logic        busy, done, err, mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        busy_s0, done_s0, err_s0, mem_valid_s0;
  logic [31:0] mem_addr_s0, mem_wdata_s0;
  logic [3:0]  mem_wstrb_s0;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  p23_store_aligner #(.MISALIGNED_SPLIT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .STOREop(store_op), .amo_store(amo_store),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  p23_store_aligner #(.MISALIGNED_SPLIT(0)) dut_s0 (
    .clk(clk), .reset(reset), .start(start2), .STOREop(store_op), .amo_store(amo_store),
    .addr(addr), .wdata(wdata), .busy(busy_s0), .done(done_s0), .err(err_s0),
    .mem_valid(mem_valid_s0), .mem_ready(mem_ready), .mem_addr(mem_addr_s0),
    .mem_wdata(mem_wdata_s0), .mem_wstrb(mem_wstrb_s0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    check_val({tag, ".valid"}, {31'h0, mem_valid}, 32'h1);
    check_val({tag, ".addr"}, mem_addr, a);
    check_val({tag, ".wdata"}, mem_wdata, d);
    check_val({tag, ".wstrb"}, {28'h0, mem_wstrb}, {28'h0, s});
    check_val({tag, ".done"}, {31'h0, done}, 32'h0);
  endtask

  task automatic check_done(input string tag, input logic exp_err);
    check_val({tag, ".done"}, {31'h0, done}, 32'h1);
    check_val({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
    check_val({tag, ".valid"}, {31'h0, mem_valid}, 32'h0);
    check_val({tag, ".busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; amo_store = 1'b0; mem_ready = 1'b0;
    store_op = 2'd0; addr = 32'h0; wdata = 32'h0;
    step(); step();
    check_val("rst.busy", {31'h0, busy}, 32'h0);
    check_val("rst.done", {31'h0, done}, 32'h0);
    check_val("rst.err", {31'h0, err}, 32'h0);
    check_val("rst.valid", {31'h0, mem_valid}, 32'h0);
    check_val("rst.addr", mem_addr, 32'h0);
    check_val("rst.wdata", mem_wdata, 32'h0);
    check_val("rst.wstrb", {28'h0, mem_wstrb}, 32'h0);
    reset = 1'b0;
    step();

    $display("txn SB aligned addr=0x1003 wdata=0xAABBCCDD");
    store_op = 2'd0; addr = 32'h0000_1003; wdata = 32'hAABB_CCDD; mem_ready = 1'b1; start = 1'b1;
    check_val("sb.t0.busy", {31'h0, busy}, 32'h0);
    step(); start = 1'b0;
    check_beat("sb.b1", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
    check_val("sb.t1.busy", {31'h0, busy}, 32'h1);
    step();
    check_done("sb.fin", 1'b0);

    $display("txn SH crossing addr=0x2003 wdata=0x00001234 (started in FIN)");
    store_op = 2'd1; addr = 32'h0000_2003; wdata = 32'h0000_1234; start = 1'b1;
    step(); start = 1'b0;
    check_beat("sh.b1", 32'h0000_2000, 32'h3400_0000, 4'b1000);
    step();
    check_beat("sh.b2", 32'h0000_2004, 32'h0000_0012, 4'b0001);
    step();
    check_done("sh.fin", 1'b0);
    step();
    check_val("sh.pulse", {31'h0, done}, 32'h0);

    $display("txn SW crossing wrap addr=0xFFFFFFFE wdata=0x11223344");
    store_op = 2'd2; addr = 32'hFFFF_FFFE; wdata = 32'h1122_3344; start = 1'b1;
    step(); start = 1'b0;
    check_beat("sw.b1", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
    step();
    check_beat("sw.b2", 32'h0000_0000, 32'h0000_1122, 4'b0011);
    step();
    check_done("sw.fin", 1'b0);
    step();

    $display("txn AMO backpressure addr=0x40 wdata=0xCAFEF00D ready low 3 cycles");
    amo_store = 1'b1; store_op = 2'd0; addr = 32'h0000_0040; wdata = 32'hCAFE_F00D;
    mem_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    check_beat("amo.c1", 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
    step();
    check_beat("amo.c2", 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
    amo_store = 1'b0; addr = 32'h0000_0080; wdata = 32'h0; start = 1'b1;
    step(); start = 1'b0;
    check_beat("amo.c3", 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
    step();
    check_beat("amo.c4", 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
    mem_ready = 1'b1;
    step();
    check_done("amo.fin", 1'b0);
    step();
    check_val("amo.ignored.valid", {31'h0, mem_valid}, 32'h0);
    check_val("amo.ignored.done", {31'h0, done}, 32'h0);

    $display("txn reject illegal STOREop=3 addr=0x100");
    store_op = 2'd3; addr = 32'h0000_0100; start = 1'b1;
    step(); start = 1'b0;
    check_done("ill.fin", 1'b1);
    step();
    check_val("ill.pulse.done", {31'h0, done}, 32'h0);
    check_val("ill.pulse.err", {31'h0, err}, 32'h0);

    $display("txn no-split SW crossing addr=0x41");
    store_op = 2'd2; addr = 32'h0000_0041; wdata = 32'h0102_0304; start2 = 1'b1;
    step(); start2 = 1'b0;
    check_val("ns.done", {31'h0, done_s0}, 32'h1);
    check_val("ns.err", {31'h0, err_s0}, 32'h1);
    check_val("ns.valid", {31'h0, mem_valid_s0}, 32'h0);
    check_val("ns.other.done", {31'h0, done}, 32'h0);
    step();

    $display("txn no-split SH aligned-in-word addr=0x42 wdata=0x0000BEEF");
    store_op = 2'd1; addr = 32'h0000_0042; wdata = 32'h0000_BEEF; start2 = 1'b1;
    step(); start2 = 1'b0;
    check_val("ns2.valid", {31'h0, mem_valid_s0}, 32'h1);
    check_val("ns2.addr", mem_addr_s0, 32'h0000_0040);
    check_val("ns2.wdata", mem_wdata_s0, 32'hBEEF_0000);
    check_val("ns2.wstrb", {28'h0, mem_wstrb_s0}, 32'hC);
    step();
    check_val("ns2.done", {31'h0, done_s0}, 32'h1);
    check_val("ns2.err", {31'h0, err_s0}, 32'h0);
    step();

    $display("txn reset mid-BEAT1 SW addr=0x300");
    store_op = 2'd2; addr = 32'h0000_0300; wdata = 32'h0000_0055; mem_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    check_val("rmid.valid.before", {31'h0, mem_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_val("rmid.valid", {31'h0, mem_valid}, 32'h0);
    check_val("rmid.busy", {31'h0, busy}, 32'h0);
    check_val("rmid.addr", mem_addr, 32'h0);
    check_val("rmid.wdata", mem_wdata, 32'h0);
    check_val("rmid.wstrb", {28'h0, mem_wstrb}, 32'h0);
    step(); reset = 1'b0; mem_ready = 1'b1;
    check_val("rmid.done1", {31'h0, done}, 32'h0);
    step();
    check_val("rmid.done2", {31'h0, done}, 32'h0);
    check_val("rmid.valid2", {31'h0, mem_valid}, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
